// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master (IFU = m0, LSU = m1) AXI-lite read arbiter in
// front of a single shared slave. One transaction in flight at a time.
// Build option: define ARB_RR_EN for round-robin on simultaneous requests;
// left undefined, m1 (LSU) wins every tie.
//
// state | meaning
// IDLE  | no transaction; a pending request is registered as owner
// ADDR  | owner's read address forwarded to the slave
// RESP  | slave read data routed back to the owner
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_ar_valid_i,
    input  logic [ADDR_W-1:0] m0_ar_addr_i,
    output logic              m0_ar_ready_o,
    output logic              m0_r_valid_o,
    output logic [DATA_W-1:0] m0_r_data_o,
    output logic [1:0]        m0_r_resp_o,
    input  logic              m0_r_ready_i,

    input  logic              m1_ar_valid_i,
    input  logic [ADDR_W-1:0] m1_ar_addr_i,
    output logic              m1_ar_ready_o,
    output logic              m1_r_valid_o,
    output logic [DATA_W-1:0] m1_r_data_o,
    output logic [1:0]        m1_r_resp_o,
    input  logic              m1_r_ready_i,

    output logic              s_ar_valid_o,
    output logic [ADDR_W-1:0] s_ar_addr_o,
    input  logic              s_ar_ready_i,
    input  logic              s_r_valid_i,
    input  logic [DATA_W-1:0] s_r_data_i,
    input  logic [1:0]        s_r_resp_i,
    output logic              s_r_ready_o,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;        // 0 = m0, 1 = m1
    logic   last_grant;
    logic   any_req;
    logic   winner;
    logic   in_addr;
    logic   in_resp;
    logic   own_ar_valid;
    logic   own_r_ready;

    assign any_req = m0_ar_valid_i | m1_ar_valid_i;

    // Grant choice for the IDLE cycle; only consumed when any_req is high
`ifdef ARB_RR_EN
    assign winner = (m0_ar_valid_i & m1_ar_valid_i) ? ~last_grant : m1_ar_valid_i;
`else
    // m1 always wins; with no request at all the previous grant is simply held
    assign winner = m1_ar_valid_i | (~m0_ar_valid_i & last_grant);
`endif

    // Transaction sequencing: grant, address handshake, data handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ADDR;
                        busy_o     <= 1'b1;
                    end
                end
                ADDR: begin
                    if (s_ar_valid_o && s_ar_ready_i) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (s_r_valid_i && s_r_ready_o) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign in_addr      = (state == ADDR);
    assign in_resp      = (state == RESP);
    assign own_ar_valid = owner ? m1_ar_valid_i : m0_ar_valid_i;
    assign own_r_ready  = owner ? m1_r_ready_i  : m0_r_ready_i;

    // Channel steering: only the owner sees handshakes, everything else is zero
    always_comb begin
        s_ar_valid_o  = 1'b0;
        s_ar_addr_o   = '0;
        s_r_ready_o   = 1'b0;
        m0_ar_ready_o = 1'b0;
        m1_ar_ready_o = 1'b0;
        m0_r_valid_o  = 1'b0;
        m0_r_data_o   = '0;
        m0_r_resp_o   = 2'b00;
        m1_r_valid_o  = 1'b0;
        m1_r_data_o   = '0;
        m1_r_resp_o   = 2'b00;
        if (in_addr) begin
            s_ar_valid_o = own_ar_valid;
            s_ar_addr_o  = owner ? m1_ar_addr_i : m0_ar_addr_i;
            if (owner) begin
                m1_ar_ready_o = s_ar_ready_i;
            end else begin
                m0_ar_ready_o = s_ar_ready_i;
            end
        end
        if (in_resp) begin
            s_r_ready_o = own_r_ready;
            if (owner) begin
                m1_r_valid_o = s_r_valid_i;
                m1_r_data_o  = s_r_data_i;
                m1_r_resp_o  = s_r_resp_i;
            end else begin
                m0_r_valid_o = s_r_valid_i;
                m0_r_data_o  = s_r_data_i;
                m0_r_resp_o  = s_r_resp_i;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; expectations follow ARB_RR_EN.
module tb_axi_rd_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_ar_valid_i, m1_ar_valid_i;
    logic [31:0] m0_ar_addr_i, m1_ar_addr_i;
    logic        m0_ar_ready_o, m1_ar_ready_o;
    logic        m0_r_valid_o, m1_r_valid_o;
    logic [31:0] m0_r_data_o, m1_r_data_o;
    logic [1:0]  m0_r_resp_o, m1_r_resp_o;
    logic        m0_r_ready_i, m1_r_ready_i;
    logic        s_ar_valid_o, s_ar_ready_i;
    logic [31:0] s_ar_addr_o;
    logic        s_r_valid_i, s_r_ready_o;
    logic [31:0] s_r_data_i;
    logic [1:0]  s_r_resp_i;
    logic        busy_o;
    logic [106:0] all_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_ready_o(m0_ar_ready_o),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
        .m0_r_ready_i(m0_r_ready_i),
        .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_ready_o(m1_ar_ready_o),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
        .m1_r_ready_i(m1_r_ready_i),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
        .s_r_ready_o(s_r_ready_o),
        .busy_o(busy_o)
    );

    assign all_out = {m0_ar_ready_o, m0_r_valid_o, m0_r_data_o, m0_r_resp_o,
                      m1_ar_ready_o, m1_r_valid_o, m1_r_data_o, m1_r_resp_o,
                      s_ar_valid_o, s_ar_addr_o, s_r_ready_o, busy_o};

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        m0_ar_valid_i = 0; m0_ar_addr_i = 0; m0_r_ready_i = 1;
        m1_ar_valid_i = 0; m1_ar_addr_i = 0; m1_r_ready_i = 1;
        s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = 0; s_r_resp_i = 0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    // Plays the slave for one full transaction starting in an IDLE cycle.
    task automatic serve(input int ar_wait, input int r_wait, input logic [31:0] data,
                         input logic [1:0] resp, input bit rearm, input bit late_m1,
                         output int who, output int busy_cnt, output logic [31:0] got_data,
                         output logic [1:0] got_resp, output logic [31:0] got_addr);
        int  acnt = 0;
        int  rcnt = 0;
        bit  done = 0;
        bit  drop0 = 0;
        bit  drop1 = 0;
        bit  first = 1;
        who = -1; busy_cnt = 0; got_data = 0; got_resp = 0; got_addr = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (drop0) m0_ar_valid_i = 0;
            if (drop1) m1_ar_valid_i = 0;
            drop0 = 0; drop1 = 0;
            s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = 0; s_r_resp_i = 0;
            #1;
            if (first) begin
                checks++;
                if (busy_o !== 0 || m0_ar_ready_o !== 0 || m1_ar_ready_o !== 0 ||
                    s_ar_valid_o !== 0 || s_ar_addr_o !== 0 || s_r_ready_o !== 0) begin
                    errors++;
                    $display("FAIL idle_gap: busy=%b ar_ready=%b%b s_ar_valid=%b s_ar_addr=%h s_r_ready=%b, required all 0",
                             busy_o, m0_ar_ready_o, m1_ar_ready_o, s_ar_valid_o, s_ar_addr_o, s_r_ready_o);
                end
                first = 0;
            end
            if (s_ar_valid_o) begin
                if (acnt == ar_wait) s_ar_ready_i = 1;
                else acnt++;
            end
            if (s_r_ready_o) begin
                if (late_m1) begin
                    m1_ar_valid_i = 1;
                    m1_ar_addr_i  = 32'h8000_1000;
                end
                if (rcnt == r_wait) begin
                    s_r_valid_i = 1; s_r_data_i = data; s_r_resp_i = resp;
                end else begin
                    rcnt++;
                end
            end
            #1;
            if (busy_o) busy_cnt++;
            if (s_ar_ready_i && s_ar_valid_o) begin
                got_addr = s_ar_addr_o;
                if (m0_ar_ready_o && !m1_ar_ready_o) who = 0;
                else if (m1_ar_ready_o && !m0_ar_ready_o) who = 1;
                else who = 2;
                if (!rearm) begin
                    if (who == 0) drop0 = 1;
                    if (who == 1) drop1 = 1;
                end
            end
            if (s_r_valid_i && s_r_ready_o) begin
                checks++;
                if (who == 1) begin
                    got_data = m1_r_data_o; got_resp = m1_r_resp_o;
                    if (m1_r_valid_o !== 1 || {m0_r_valid_o, m0_r_data_o, m0_r_resp_o} !== 0) begin
                        errors++;
                        $display("FAIL r_route_m1: m1_r_valid=%b m0 r=%b/%h/%b, required 1 and zeros",
                                 m1_r_valid_o, m0_r_valid_o, m0_r_data_o, m0_r_resp_o);
                    end
                end else begin
                    got_data = m0_r_data_o; got_resp = m0_r_resp_o;
                    if (m0_r_valid_o !== 1 || {m1_r_valid_o, m1_r_data_o, m1_r_resp_o} !== 0) begin
                        errors++;
                        $display("FAIL r_route_m0: m0_r_valid=%b m1 r=%b/%h/%b, required 1 and zeros",
                                 m0_r_valid_o, m1_r_valid_o, m1_r_data_o, m1_r_resp_o);
                    end
                end
                done = 1;
            end
            @(posedge clk_i);
            #1;
        end
        s_r_valid_i = 0; s_r_data_i = 0; s_r_resp_i = 0; s_ar_ready_i = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL serve_timeout: transaction done=%0d, required 1", done);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        m0_ar_valid_i = 1; m1_ar_valid_i = 1; s_ar_ready_i = 1; s_r_valid_i = 1;
        s_r_data_i = 32'hFFFF_FFFF; s_r_resp_i = 2'b11;
        rst_i = 1;
        tick();
        tick();
        checks++;
        if (all_out !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        clear_inputs();
        rst_i = 0;
        #1;
        checks++;
        if (busy_o !== 0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b, required 0", busy_o);
        end
        tick();
    endtask

    task automatic test_single;
        int who, bc;
        logic [31:0] d, a;
        logic [1:0]  r;
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0000;
        serve(2, 2, 32'h0000_0413, 2'b00, 0, 0, who, bc, d, r, a);
        checks++;
        if (who != 0) begin errors++; $display("FAIL single_owner: got %0d, required 0", who); end
        checks++;
        if (a !== 32'h8000_0000) begin errors++; $display("FAIL single_addr: got %h, required 80000000", a); end
        checks++;
        if (d !== 32'h0000_0413) begin errors++; $display("FAIL single_data: got %h, required 00000413", d); end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL single_resp: got %b, required 00", r); end
        checks++;
        if (bc != 6) begin errors++; $display("FAIL single_busy_cycles: got %0d, required 6", bc); end
    endtask

    task automatic test_arbitration;
        int who, bc;
        logic [31:0] d, a;
        logic [1:0]  r;
        int exp_who[5];
`ifdef ARB_RR_EN
        exp_who = '{0, 1, 0, 1, 0};
`else
        exp_who = '{1, 1, 1, 1, 0};
`endif
        apply_reset();
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0000;
        m1_ar_valid_i = 1; m1_ar_addr_i = 32'h8000_1000;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1, 32'h100 + i, 2'b00, (i < 3), 0, who, bc, d, r, a);
            checks++;
            if (who != exp_who[i]) begin
                errors++;
                $display("FAIL arb_round%0d_owner: got %0d, required %0d", i, who, exp_who[i]);
            end
            checks++;
            if (a !== (exp_who[i] == 1 ? 32'h8000_1000 : 32'h8000_0000) || d !== 32'h100 + i) begin
                errors++;
                $display("FAIL arb_round%0d_addr_data: got %h/%h, required owner %0d addr and data %h",
                         i, a, d, exp_who[i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_resp_err;
        int who, bc;
        logic [31:0] d, a;
        logic [1:0]  r;
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0040;
        serve(0, 1, 32'hDEAD_BEEF, 2'b10, 0, 1, who, bc, d, r, a);
        checks++;
        if (who != 0 || r !== 2'b10 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL slverr_m0: owner=%0d resp=%b data=%h, required 0/10/deadbeef", who, r, d);
        end
        serve(1, 0, 32'h1234_5678, 2'b11, 0, 0, who, bc, d, r, a);
        checks++;
        if (who != 1 || a !== 32'h8000_1000) begin
            errors++;
            $display("FAIL waited_m1_grant: owner=%0d addr=%h, required 1/80001000", who, a);
        end
        checks++;
        if (r !== 2'b11 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL decerr_m1: resp=%b data=%h, required 11/12345678", r, d);
        end
    endtask

    task automatic test_violation;
        int who, bc;
        logic [31:0] d, a;
        logic [1:0]  r;
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0080;
        tick();
        checks++;
        if (busy_o !== 1 || s_ar_valid_o !== 1 || s_ar_addr_o !== 32'h8000_0080) begin
            errors++;
            $display("FAIL viol_addr_phase: busy=%b s_ar_valid=%b addr=%h, required 1/1/80000080",
                     busy_o, s_ar_valid_o, s_ar_addr_o);
        end
        m0_ar_valid_i = 0;
        m1_ar_valid_i = 1; m1_ar_addr_i = 32'h8000_00C0;
        s_ar_ready_i = 1;
        tick();
        checks++;
        if (busy_o !== 1 || s_ar_valid_o !== 0 || m1_ar_ready_o !== 0 || s_ar_addr_o !== 32'h8000_0080) begin
            errors++;
            $display("FAIL viol_hold: busy=%b s_ar_valid=%b m1_ar_ready=%b addr=%h, required 1/0/0/80000080",
                     busy_o, s_ar_valid_o, m1_ar_ready_o, s_ar_addr_o);
        end
        m0_ar_valid_i = 1;
        #1;
        checks++;
        if (m0_ar_ready_o !== 1 || s_ar_valid_o !== 1) begin
            errors++;
            $display("FAIL viol_resume: m0_ar_ready=%b s_ar_valid=%b, required 1/1", m0_ar_ready_o, s_ar_valid_o);
        end
        tick();
        m0_ar_valid_i = 0; s_ar_ready_i = 0;
        s_r_valid_i = 1; s_r_data_i = 32'h0000_00AA; s_r_resp_i = 2'b00;
        #1;
        checks++;
        if (m0_r_valid_o !== 1 || m0_r_data_o !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL viol_resp: m0_r_valid=%b data=%h, required 1/000000aa", m0_r_valid_o, m0_r_data_o);
        end
        tick();
        s_r_valid_i = 0; s_r_data_i = 0;
        serve(0, 0, 32'h0000_00BB, 2'b01, 0, 0, who, bc, d, r, a);
        checks++;
        if (who != 1 || a !== 32'h8000_00C0 || r !== 2'b01) begin
            errors++;
            $display("FAIL viol_m1_waited: owner=%0d addr=%h resp=%b, required 1/800000c0/01", who, a, r);
        end
    endtask

    task automatic test_reset_mid_resp;
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0100; s_ar_ready_i = 1;
        tick();
        tick();
        m0_ar_valid_i = 0; s_ar_ready_i = 0; m0_r_ready_i = 0;
        s_r_valid_i = 1; s_r_data_i = 32'h0000_0055;
        #1;
        checks++;
        if (m0_r_valid_o !== 1 || busy_o !== 1) begin
            errors++;
            $display("FAIL mid_resp_setup: m0_r_valid=%b busy=%b, required 1/1", m0_r_valid_o, busy_o);
        end
        #1;
        rst_i = 1;
        #1;
        checks++;
        if (all_out !== 0) begin
            errors++;
            $display("FAIL mid_resp_reset: outputs %h, required 0", all_out);
        end
        m0_r_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m0_r_valid_o !== 0 || busy_o !== 0) begin
                errors++;
                $display("FAIL mid_resp_hold%0d: m0_r_valid=%b busy=%b, required 0/0", i, m0_r_valid_o, busy_o);
            end
        end
        clear_inputs();
        rst_i = 0;
        tick();
        checks++;
        if (all_out !== 0) begin
            errors++;
            $display("FAIL mid_resp_after: outputs %h, required 0", all_out);
        end
    endtask

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_single();
        test_arbitration();
        test_resp_err();
        test_violation();
        test_reset_mid_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
